// File: rtl/adder_seq_ctrl_pkg.sv
// Shared constants for the nibble-serial add/subtract sequencer.
package adder_seq_ctrl_pkg;

    localparam int unsigned SLICE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Operand width must split evenly into slice-sized nibbles.
    function automatic bit width_ok(input int unsigned w);
        return (w % SLICE_W) == 0 && w != 0;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Operand request / result handshake bundle for adder_seq_ctrl.
interface adder_seq_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/adder_seq_ctrl_slice.sv
// 4-bit ripple-carry adder slice, purely combinational.
module adder_seq_ctrl_slice
    import adder_seq_ctrl_pkg::*;
(
    output logic               cout,
    output logic [SLICE_W-1:0] sum,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin
);
    localparam int unsigned SW1 = SLICE_W + 1;

    // Widened add so the carry-out lands in the top bit.
    assign {cout, sum} = SW1'(a) + SW1'(b) + SW1'(cin);
endmodule

// File: rtl/adder_seq_ctrl.sv
// Time-multiplexed WIDTH-bit add/subtract using one 4-bit slice, LS nibble first.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_seq_ctrl_if.slave    bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned EXT_W  = WIDTH + SLICE_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("adder_seq_ctrl: WIDTH must be a non-zero multiple of 4");
    end

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_cout;

    adder_seq_ctrl_slice u_slice (
        .cout (w_slice_cout),
        .sum  (w_slice_sum),
        .a    (r_a[SLICE_W-1:0]),
        .b    (r_b[SLICE_W-1:0]),
        .cin  (r_carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode plus accept/run strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch, nibble shifting, carry chain and overflow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
            r_a_msb <= bus.in_a[WIDTH-1];
            r_b_msb <= bus.in_sub ? ~bus.in_b[WIDTH-1] : bus.in_b[WIDTH-1];
            r_carry <= bus.in_sub ? 1'b1 : bus.in_cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_sum   <= WIDTH'({w_slice_sum, r_sum} >> SLICE_W);
            r_a     <= r_a >> SLICE_W;
            r_b     <= r_b >> SLICE_W;
            r_carry <= w_slice_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            // Carry into the MSB is a^b^sum there; xor with carry-out gives overflow.
            if (w_last) r_ovf <= r_a_msb ^ r_b_msb ^ w_slice_sum[SLICE_W-1] ^ w_slice_cout;
        end
    end

    // Registered handshake/status flags track the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_carry;
    assign bus.out_ovf   = r_ovf;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl: vector table plus backpressure and reset-abort sequences.
module tb_adder_seq_ctrl;
    localparam int unsigned WIDTH = 16;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    adder_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the handshake edge.
    task automatic run_op(input vec_t v);
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({v.name, " ready_wait"}, 32'(guard < 20), 32'd1);
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        bus.in_cin   = v.cin;
        bus.in_sub   = v.sub;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({v.name, " busy"}, 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check({v.name, " latency"}, 32'(bus.out_valid), 32'(k == 4));
        end
        check({v.name, " sum"},  32'(bus.out_sum),  32'(v.sum));
        check({v.name, " cout"}, 32'(bus.out_cout), 32'(v.cout));
        check({v.name, " ovf"},  32'(bus.out_ovf),  32'(v.ovf));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({v.name, " drop_valid"}, 32'(bus.out_valid), 32'd0);
        check({v.name, " ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{"add_00ff_1",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{"add_ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"sub_5_7",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{"sub_7_5",      16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[4] = '{"add_7fff_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{"sub_8000_1",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{"sub_cin_ign",  16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{"add_neg_ovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready",  32'(bus.in_ready),  32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_sum",   32'(bus.out_sum),   32'd0);
        check("rst out_cout",  32'(bus.out_cout),  32'd0);
        check("rst out_ovf",   32'(bus.out_ovf),   32'd0);
        check("rst busy",      32'(bus.busy),      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Backpressure: hold the result for three cycles while a new request waits.
        bus.in_a = 16'h0001; bus.in_b = 16'h0002; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.in_a = 16'h0010; bus.in_b = 16'h0020; bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp out_sum",   32'(bus.out_sum),   32'h0003);
            check("bp in_ready",  32'(bus.in_ready),  32'd0);
            @(posedge clk); #1;
        end
        check("bp held sum", 32'(bus.out_sum), 32'h0003);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp no_overlap busy",  32'(bus.busy),      32'd0);
        check("bp no_overlap ready", 32'(bus.in_ready),  32'd1);
        check("bp valid_drop",       32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp next accept busy", 32'(bus.busy), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("bp next latency", 32'(bus.out_valid), 32'(k == 4));
        end
        check("bp next sum", 32'(bus.out_sum), 32'h0030);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset pulsed during the second RUN cycle aborts the operation.
        bus.in_a = 16'hFFFF; bus.in_b = 16'h0001; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort in_ready",  32'(bus.in_ready),  32'd1);
        check("abort busy",      32'(bus.busy),      32'd0);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort out_sum",   32'(bus.out_sum),   32'd0);
        check("abort out_cout",  32'(bus.out_cout),  32'd0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("abort no_valid", 32'(bus.out_valid), 32'd0);
        end
        v = '{"post_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        run_op(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit ripple-carry slice over WIDTH/4 cycles, least-significant nibble first, with a registered carry between slices. Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Trades latency for area where a full-width adder tree is not justified.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4, otherwise elaboration error
NSLICE, WIDTH/4, derived localparam: number of slice cycles

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept operands
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in; used for ADD only
in_sub  in  1  0 = A+B+cin, 1 = A-B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  result
out_cout  out  1  carry-out of MSB slice (SUB: 1 = no borrow)
out_ovf  out  1  two's-complement signed overflow
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, slice counter=0, carry reg=0, operand/sum shift regs=0; in_ready=1 on release, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On edge with in_valid=1: latch A, B_eff (B if ADD, ~B if SUB), MSBs of A and B_eff for ovf; carry reg = in_cin (ADD) or 1 (SUB, in_cin ignored); counter=0; go RUN.
- RUN: in_ready=0. Each cycle the slice adds A[3:0], B_eff[3:0] and the carry reg; at the edge the slice sum shifts into the top of the sum reg (sum reg shifts right by 4), A/B_eff shift right by 4, carry reg takes slice cout, counter increments. At the edge where counter == NSLICE-1, go DONE.
- Latency: out_valid rises exactly NSLICE cycles after the accept edge (4 for WIDTH=16).
- DONE: out_valid=1; out_sum = sum reg; out_cout = carry reg; out_ovf = A_msb ^ B_eff_msb ^ sum_msb ^ carry reg. Outputs held stable while out_valid=1 and out_ready=0 (unbounded backpressure). On edge with out_ready=1: go IDLE, out_valid=0.
- No overlap: new operands are not accepted in DONE, even when out_ready=1 in the same cycle; earliest next accept is the cycle after the result is consumed. Throughput is 1 op per NSLICE+2 cycles under full flow.
- in_valid while not in IDLE is ignored; the producer holds its request until in_ready.
- out_sum/out_cout/out_ovf are don't-care when out_valid=0 but must not be X after reset.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately, all state returns to reset values, and no out_valid pulse follows.
- Wrap-around: sum is modulo 2^WIDTH; the carry is reported only via out_cout.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DONE), SLICE_W=4 constant, WIDTH%4 check helper.
- One sub-module: the team's existing 4-bit ripple-carry slice adder (ports cout, sum, a, b, cin), instantiated once as the combinational datapath. The FSM, counter, carry reg and shift regs live in adder_seq_ctrl.

Test Plan:
- ADD 0x00FF + 0x0001, cin=0 -> out_sum=0x0100, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- ADD 0xFFFF + 0x0000, cin=1 -> out_sum=0x0000, cout=1, ovf=0 (full carry ripple across all slices).
- SUB 0x0005 - 0x0007 -> out_sum=0xFFFE, cout=0 (borrow), ovf=0; SUB 0x0007 - 0x0005 -> 0x0002, cout=1.
- ADD 0x7FFF + 0x0001 -> 0x8000, ovf=1; SUB 0x8000 - 0x0001 -> 0x7FFF, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0 throughout; in_valid asserted meanwhile is not accepted until the cycle after the out_ready handshake.
- rst_n pulsed low in the 2nd RUN cycle -> asynchronous return to reset values, no out_valid; next op 0x1234 + 0x1111 -> 0x2345.
